// File: rtl/canvas_pkg.sv
// canvas_pkg
// Shared definitions for the pixel canvas front end of the digit classifier.
//   CANVAS_DIM    : canvas edge length in pixels (28)
//   CANVAS_PIX    : total pixel count, width of the pixel bus (784)
//   DIGIT_INVALID : result code shown when no classification is held
//   state_e       : controller states (edit, start request, wait for network)
//   pix_index     : maps a (x, y) coordinate to its bit in the pixel bus
package canvas_pkg;

  localparam int CANVAS_DIM = 28;
  localparam int CANVAS_PIX = 784;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_EDIT     = 2'd0,
    ST_RUN_REQ  = 2'd1,
    ST_RUN_WAIT = 2'd2
  } state_e;

  // Row-major layout: bit index = y*28 + x, always below 784 for legal coordinates.
  function automatic logic [9:0] pix_index(input logic [4:0] x, input logic [4:0] y);
    return 10'(y) * 10'(CANVAS_DIM) + 10'(x);
  endfunction

endpackage

// File: rtl/canvas_brush_mask.sv
// canvas_brush_mask
// Combinational brush footprint generator. Turns the cursor position into a
// 784-bit write mask used by the canvas update.
// Configuration macro: CANVAS_BRUSH3_EN
//   defined   : 3x3 block centred on the cursor, off-canvas cells dropped
//   undefined : only the cursor pixel
// Ports:
//   cursor_x, cursor_y : cursor coordinates, 0..27
//   mask               : one bit per canvas pixel that the brush touches
module canvas_brush_mask
  import canvas_pkg::*;
(
  input  logic [4:0]            cursor_x,
  input  logic [4:0]            cursor_y,
  output logic [CANVAS_PIX-1:0] mask
);

`ifdef CANVAS_BRUSH3_EN
  int px;
  int py;
`endif

  // Build the footprint; neighbours are clipped per axis so a brush on the
  // left edge never spills into the end of the previous row.
  always_comb begin
    mask = '0;
`ifdef CANVAS_BRUSH3_EN
    px = 0;
    py = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        px = int'(cursor_x) + dx;
        py = int'(cursor_y) + dy;
        if (px >= 0 && px < CANVAS_DIM && py >= 0 && py < CANVAS_DIM) begin
          mask[pix_index(5'(px), 5'(py))] = 1'b1;
        end
      end
    end
`else
    mask[pix_index(cursor_x, cursor_y)] = 1'b1;
`endif
  end

endmodule

// File: rtl/pixel_canvas_ctrl.sv
// pixel_canvas_ctrl
// Front end for the digit classifier network: holds the 28x28 binary canvas,
// moves a cursor, paints/erases, and runs one classification per request
// with a watchdog that recovers if the network never reports done.
// Configuration macro: CANVAS_BRUSH3_EN (3x3 brush, see canvas_brush_mask).
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed waiting for nn_done (>= 2)
//   CURSOR_RST     : reset value of both cursor coordinates (0..27)
// Ports:
//   clk, resetn                 : clock, synchronous active-high reset
//   mv_up/down/left/right       : one-cycle cursor steps (up decreases y)
//   paint, ink                  : brush write enable and value
//   clear                       : zero the canvas and drop the result
//   run                         : request a classification
//   nn_done, nn_argmax          : network completion and answer
//   pixel_data                  : canvas, bit y*28+x
//   nn_start                    : one-cycle start pulse to the network
//   cursor_x, cursor_y          : cursor position
//   busy                        : classification in progress
//   result_valid, result_digit  : latched answer (4'hF when invalid)
//   timeout                     : sticky, last run was aborted
module pixel_canvas_ctrl
  import canvas_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CURSOR_RST     = 13
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mv_up,
  input  logic                  mv_down,
  input  logic                  mv_left,
  input  logic                  mv_right,
  input  logic                  paint,
  input  logic                  ink,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  nn_done,
  input  logic [3:0]            nn_argmax,
  output logic [CANVAS_PIX-1:0] pixel_data,
  output logic                  nn_start,
  output logic [4:0]            cursor_x,
  output logic [4:0]            cursor_y,
  output logic                  busy,
  output logic                  result_valid,
  output logic [3:0]            result_digit,
  output logic                  timeout
);

  localparam int         WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] COORD_MAX = 5'(CANVAS_DIM - 1);
  localparam logic [4:0] COORD_RST = 5'(CURSOR_RST);

  state_e                state_q, state_d;
  logic [CANVAS_PIX-1:0] pix_q, pix_d;
  logic [4:0]            cx_q, cx_d, cy_q, cy_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [3:0]            digit_q, digit_d;
  logic                  tout_q, tout_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [CANVAS_PIX-1:0] brushMask;

  canvas_brush_mask u_mask (
    .cursor_x (cx_q),
    .cursor_y (cy_q),
    .mask     (brushMask)
  );

  // Next-state logic. Paint uses the pre-move cursor because the mask is
  // derived from the registered position; clear takes priority over paint.
  // nn_start and busy are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    digit_d = digit_q;
    tout_d  = tout_q;
    wd_d    = wd_q;
    case (state_q)
      ST_EDIT: begin
        if (clear) begin
          pix_d   = '0;
          valid_d = 1'b0;
          digit_d = DIGIT_INVALID;
          tout_d  = 1'b0;
        end else if (paint) begin
          pix_d = (pix_q & ~brushMask) | (brushMask & {CANVAS_PIX{ink}});
        end
        if (mv_right && !mv_left && cx_q != COORD_MAX) cx_d = cx_q + 5'd1;
        if (mv_left && !mv_right && cx_q != 5'd0)      cx_d = cx_q - 5'd1;
        if (mv_down && !mv_up && cy_q != COORD_MAX)    cy_d = cy_q + 5'd1;
        if (mv_up && !mv_down && cy_q != 5'd0)         cy_d = cy_q - 5'd1;
        if (run) begin
          state_d = ST_RUN_REQ;
          valid_d = 1'b0;
          digit_d = DIGIT_INVALID;
          tout_d  = 1'b0;
        end
      end
      ST_RUN_REQ: begin
        wd_d    = WD_LOAD;
        state_d = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: begin
        if (nn_done) begin
          digit_d = nn_argmax;
          valid_d = 1'b1;
          state_d = ST_EDIT;
        end else if (wd_q == '0) begin
          tout_d  = 1'b1;
          digit_d = DIGIT_INVALID;
          state_d = ST_EDIT;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      default: state_d = ST_EDIT;
    endcase
    start_d = (state_d == ST_RUN_REQ);
    busy_d  = (state_d != ST_EDIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_EDIT;
      pix_q   <= '0;
      cx_q    <= COORD_RST;
      cy_q    <= COORD_RST;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      digit_q <= DIGIT_INVALID;
      tout_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
      tout_q  <= tout_d;
      wd_q    <= wd_d;
    end
  end

  assign pixel_data   = pix_q;
  assign nn_start     = start_q;
  assign cursor_x     = cx_q;
  assign cursor_y     = cy_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result_digit = digit_q;
  assign timeout      = tout_q;

endmodule

// File: tb/tb_pixel_canvas_ctrl.sv
// tb_pixel_canvas_ctrl
// Directed testbench for pixel_canvas_ctrl. Two instances share all inputs:
// dutA has a long watchdog and is used for the editing and normal run checks,
// dutB has TIMEOUT_CYCLES = 16 and is used for the watchdog checks.
// Honors CANVAS_BRUSH3_EN for the expected brush footprints.
module tb_pixel_canvas_ctrl;

  logic clk = 1'b0;
  logic resetn, mv_up, mv_down, mv_left, mv_right;
  logic paint, ink, clear, run, nn_done;
  logic [3:0] nn_argmax;

  logic [783:0] pixA, pixB;
  logic startA, startB, busyA, busyB, validA, validB, toutA, toutB;
  logic [4:0] cxA, cyA, cxB, cyB;
  logic [3:0] digitA, digitB;

  logic [783:0] exp53, exp63, exp00;
  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  pixel_canvas_ctrl #(.TIMEOUT_CYCLES(1000), .CURSOR_RST(13)) dutA (
    .clk(clk), .resetn(resetn), .mv_up(mv_up), .mv_down(mv_down),
    .mv_left(mv_left), .mv_right(mv_right), .paint(paint), .ink(ink),
    .clear(clear), .run(run), .nn_done(nn_done), .nn_argmax(nn_argmax),
    .pixel_data(pixA), .nn_start(startA), .cursor_x(cxA), .cursor_y(cyA),
    .busy(busyA), .result_valid(validA), .result_digit(digitA), .timeout(toutA)
  );

  pixel_canvas_ctrl #(.TIMEOUT_CYCLES(16), .CURSOR_RST(13)) dutB (
    .clk(clk), .resetn(resetn), .mv_up(mv_up), .mv_down(mv_down),
    .mv_left(mv_left), .mv_right(mv_right), .paint(paint), .ink(ink),
    .clear(clear), .run(run), .nn_done(nn_done), .nn_argmax(nn_argmax),
    .pixel_data(pixB), .nn_start(startB), .cursor_x(cxB), .cursor_y(cyB),
    .busy(busyB), .result_valid(validB), .result_digit(digitB), .timeout(toutB)
  );

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
    paint = 0; ink = 0; clear = 0; run = 0; nn_done = 0; nn_argmax = 4'd0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    nCompared++; if (cxA !== 5'd13 || cyA !== 5'd13) begin nMismatched++;
      $display("[TB] FAIL rst_cursor: got (%0d,%0d) want (13,13)", cxA, cyA); end
    nCompared++; if (pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL rst_pix: got nonzero canvas want 0"); end
    nCompared++; if (startA !== 1'b0 || busyA !== 1'b0 || validA !== 1'b0 || toutA !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL rst_flags: got start=%b busy=%b valid=%b tout=%b want 0000", startA, busyA, validA, toutA); end
    nCompared++; if (digitA !== 4'hF) begin nMismatched++;
      $display("[TB] FAIL rst_digit: got %h want F", digitA); end
  endtask

  task automatic test_saturate();
    mv_left = 1;
    repeat (14) tick();
    mv_left = 0;
    nCompared++; if (cxA !== 5'd0 || cyA !== 5'd13) begin nMismatched++;
      $display("[TB] FAIL sat_left: got (%0d,%0d) want (0,13)", cxA, cyA); end
    nCompared++; if (pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL sat_pix: got nonzero canvas want 0"); end
    mv_up = 1;
    repeat (20) tick();
    mv_up = 0;
    nCompared++; if (cyA !== 5'd0) begin nMismatched++;
      $display("[TB] FAIL sat_up: got %0d want 0", cyA); end
  endtask

  task automatic test_corner_paint();
    paint = 1; ink = 1;
    tick();
    paint = 0;
    nCompared++; if (pixA !== exp00) begin nMismatched++;
      $display("[TB] FAIL corner_paint: got bits0..29=%b want %b", pixA[29:0], exp00[29:0]); end
    nCompared++; if (pixA[783:30] !== '0) begin nMismatched++;
      $display("[TB] FAIL corner_wrap: got stray bits above 29 want none"); end
    paint = 1; ink = 0;
    tick();
    paint = 0;
    nCompared++; if (pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL corner_erase: got bits0..29=%b want 0", pixA[29:0]); end
  endtask

  task automatic test_paint();
    mv_right = 1; repeat (5) tick(); mv_right = 0;
    mv_down = 1;  repeat (3) tick(); mv_down = 0;
    nCompared++; if (cxA !== 5'd5 || cyA !== 5'd3) begin nMismatched++;
      $display("[TB] FAIL move_to_5_3: got (%0d,%0d) want (5,3)", cxA, cyA); end
    mv_left = 1; mv_right = 1; mv_down = 1;
    tick();
    idle();
    nCompared++; if (cxA !== 5'd5 || cyA !== 5'd4) begin nMismatched++;
      $display("[TB] FAIL cancel_x: got (%0d,%0d) want (5,4)", cxA, cyA); end
    mv_up = 1; tick(); mv_up = 0;
    paint = 1; ink = 1;
    tick();
    paint = 0;
    nCompared++; if (pixA !== exp53) begin nMismatched++;
      $display("[TB] FAIL paint_5_3: got bits56..123=%b want %b", pixA[123:56], exp53[123:56]); end
  endtask

  task automatic test_move_paint();
    clear = 1; tick(); clear = 0;
    nCompared++; if (pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL clear: got nonzero canvas want 0"); end
    mv_right = 1; paint = 1; ink = 1;
    tick();
    idle();
    nCompared++; if (pixA !== exp53) begin nMismatched++;
      $display("[TB] FAIL move_paint_pix: got bits56..123=%b want %b", pixA[123:56], exp53[123:56]); end
    nCompared++; if (cxA !== 5'd6) begin nMismatched++;
      $display("[TB] FAIL move_paint_x: got %0d want 6", cxA); end
    clear = 1; paint = 1; ink = 1;
    tick();
    idle();
    nCompared++; if (pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL clear_beats_paint: got nonzero canvas want 0"); end
  endtask

  task automatic test_run_done();
    int startCount;
    int busyLow;
    paint = 1; ink = 1; tick(); paint = 0;
    nCompared++; if (pixA !== exp63) begin nMismatched++;
      $display("[TB] FAIL paint_6_3: got bits56..123=%b want %b", pixA[123:56], exp63[123:56]); end
    run = 1; tick(); run = 0;
    nCompared++; if (startA !== 1'b1 || busyA !== 1'b1) begin nMismatched++;
      $display("[TB] FAIL run_t1: got start=%b busy=%b want 1 1", startA, busyA); end
    startCount = 0;
    busyLow = 0;
    for (int k = 0; k < 49; k++) begin
      paint = 1; ink = k[0]; mv_right = 1; mv_down = 1; clear = (k == 10); run = (k == 20);
      tick();
      if (startA) startCount++;
      if (!busyA) busyLow++;
    end
    idle();
    nCompared++; if (startCount !== 0) begin nMismatched++;
      $display("[TB] FAIL start_once: got %0d extra start cycles want 0", startCount); end
    nCompared++; if (busyLow !== 0) begin nMismatched++;
      $display("[TB] FAIL busy_hold: got %0d idle cycles want 0", busyLow); end
    nCompared++; if (pixA !== exp63 || cxA !== 5'd6 || cyA !== 5'd3) begin nMismatched++;
      $display("[TB] FAIL frozen: got cursor (%0d,%0d) canvas_ok=%b want (6,3) 1", cxA, cyA, pixA === exp63); end
    nn_done = 1; nn_argmax = 4'd7; tick(); idle();
    nCompared++; if (validA !== 1'b1 || digitA !== 4'd7 || busyA !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL done_result: got valid=%b digit=%h busy=%b want 1 7 0", validA, digitA, busyA); end
    nn_done = 1; nn_argmax = 4'd3; tick(); idle();
    nCompared++; if (digitA !== 4'd7 || validA !== 1'b1) begin nMismatched++;
      $display("[TB] FAIL stray_done: got valid=%b digit=%h want 1 7", validA, digitA); end
    run = 1; tick(); run = 0;
    nCompared++; if (validA !== 1'b0 || digitA !== 4'hF) begin nMismatched++;
      $display("[TB] FAIL run_drops_result: got valid=%b digit=%h want 0 F", validA, digitA); end
    tick();
    nCompared++; if (startA !== 1'b0 || busyA !== 1'b1) begin nMismatched++;
      $display("[TB] FAIL run_t2: got start=%b busy=%b want 0 1", startA, busyA); end
    nn_done = 1; nn_argmax = 4'd12; tick(); idle();
    nCompared++; if (validA !== 1'b1 || digitA !== 4'hC) begin nMismatched++;
      $display("[TB] FAIL reject_digit: got valid=%b digit=%h want 1 C", validA, digitA); end
  endtask

  task automatic test_timeout();
    run = 1; tick(); run = 0;
    nCompared++; if (busyB !== 1'b1 || startB !== 1'b1 || toutB !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL to_start: got busy=%b start=%b tout=%b want 1 1 0", busyB, startB, toutB); end
    repeat (16) tick();
    nCompared++; if (busyB !== 1'b1 || toutB !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL to_early: got busy=%b tout=%b want 1 0", busyB, toutB); end
    tick();
    nCompared++; if (toutB !== 1'b1 || busyB !== 1'b0 || digitB !== 4'hF || validB !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL to_abort: got tout=%b busy=%b digit=%h valid=%b want 1 0 F 0", toutB, busyB, digitB, validB); end
    run = 1; tick(); run = 0;
    nCompared++; if (toutB !== 1'b0 || busyB !== 1'b1) begin nMismatched++;
      $display("[TB] FAIL to_rerun: got tout=%b busy=%b want 0 1", toutB, busyB); end
    tick();
    nn_done = 1; nn_argmax = 4'd4; tick(); idle();
    nCompared++; if (validB !== 1'b1 || digitB !== 4'd4 || validA !== 1'b1 || digitA !== 4'd4) begin nMismatched++;
      $display("[TB] FAIL to_recover: got B valid=%b digit=%h A valid=%b digit=%h want 1 4 1 4", validB, digitB, validA, digitA); end
    run = 1; tick(); run = 0;
    repeat (16) tick();
    nn_done = 1; nn_argmax = 4'd9; tick(); idle();
    nCompared++; if (validB !== 1'b1 || digitB !== 4'd9 || toutB !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL done_wins: got valid=%b digit=%h tout=%b want 1 9 0", validB, digitB, toutB); end
  endtask

  task automatic test_reset_midrun();
    run = 1; tick(); run = 0;
    repeat (5) tick();
    resetn = 1; tick(); resetn = 0;
    nCompared++; if (cxA !== 5'd13 || cyA !== 5'd13 || pixA !== '0) begin nMismatched++;
      $display("[TB] FAIL mid_rst_canvas: got (%0d,%0d) canvas_zero=%b want (13,13) 1", cxA, cyA, pixA === '0); end
    nCompared++; if (startA !== 0 || busyA !== 0 || validA !== 0 || toutA !== 0 || digitA !== 4'hF) begin nMismatched++;
      $display("[TB] FAIL mid_rst_flags: got start=%b busy=%b valid=%b tout=%b digit=%h want 0 0 0 0 F", startA, busyA, validA, toutA, digitA); end
    run = 1; tick(); run = 0;
    nCompared++; if (startA !== 1'b1 || busyA !== 1'b1) begin nMismatched++;
      $display("[TB] FAIL mid_rst_rerun: got start=%b busy=%b want 1 1", startA, busyA); end
    tick();
    nn_done = 1; nn_argmax = 4'd2; tick(); idle();
    nCompared++; if (validA !== 1'b1 || digitA !== 4'd2 || busyA !== 1'b0) begin nMismatched++;
      $display("[TB] FAIL mid_rst_done: got valid=%b digit=%h busy=%b want 1 2 0", validA, digitA, busyA); end
  endtask

  // Hand-listed brush footprints; (6,3) is (5,3) shifted right by one column.
  initial begin
    exp53 = '0;
    exp00 = '0;
`ifdef CANVAS_BRUSH3_EN
    exp53[60] = 1; exp53[61] = 1; exp53[62] = 1;
    exp53[88] = 1; exp53[89] = 1; exp53[90] = 1;
    exp53[116] = 1; exp53[117] = 1; exp53[118] = 1;
    exp00[0] = 1; exp00[1] = 1; exp00[28] = 1; exp00[29] = 1;
`else
    exp53[89] = 1;
    exp00[0] = 1;
`endif
    exp63 = exp53 << 1;
    resetn = 1'b1;
    idle();
    test_reset();
    test_saturate();
    test_corner_paint();
    test_paint();
    test_move_paint();
    test_run_done();
    test_timeout();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pixel_canvas_ctrl.md
# pixel_canvas_ctrl

Upstream front end for `neural_network`: holds the 28x28 binary drawing canvas, moves a cursor and paints or erases from single-cycle user commands, and drives the 784-bit `pixel_data` bus. On a run request it freezes the canvas, issues a one-cycle `start` to the network, waits for `done`, and latches `argmax_output` as the classified digit. A timeout watchdog recovers the controller if the network never finishes.

## Interface
- `TIMEOUT_CYCLES`, default 1048576: cycles allowed in RUN_WAIT before abort; must be ≥ 2.
- `CURSOR_RST`, default 13: reset value of both cursor coordinates; range 0..27.
- `clk`  in  1  system clock.
- `resetn`  in  1  synchronous, active-high reset.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  one-cycle cursor step pulses.
- `paint`  in  1  level; while high in EDIT, set the brush pixels to `ink`.
- `ink`  in  1  value written by `paint`: 1 draws, 0 erases.
- `clear`  in  1  pulse; zero the whole canvas.
- `run`  in  1  pulse; request classification.
- `nn_done`  in  1  network `done`.
- `nn_argmax`  in  4  network `argmax_output`.
- `pixel_data`  out  784  canvas; bit index = y*28 + x.
- `nn_start`  out  1  one-cycle start pulse to the network.
- `cursor_x`, `cursor_y`  out  5 each  cursor position.
- `busy`  out  1  high in RUN_REQ and RUN_WAIT.
- `result_valid`  out  1  `result_digit` is valid.
- `result_digit`  out  4  latched classification; 4'hF when invalid.
- `timeout`  out  1  sticky; last run aborted.

## Operation
- States: EDIT, RUN_REQ, RUN_WAIT.
- EDIT: accepts moves, paint, clear, and run.
  - Moves saturate at 0 and 27; there is no wrap.
  - Opposite moves in the same cycle cancel on that axis.
  - Paint, clear and moves are accepted only in EDIT; ignored otherwise.
  - Same-cycle move and paint: paint uses the pre-move cursor; the cursor then updates.
  - `clear` beats `paint` in the same cycle.
  - `clear` also drops `result_valid`, sets `result_digit` = 4'hF, and clears `timeout`.
- `run` in EDIT:
  - Go to RUN_REQ.
  - Drop `result_valid`; set `result_digit` = 4'hF; clear `timeout`.
  - Same-cycle `clear` or `paint` is still applied before the freeze.
- RUN_REQ:
  - `nn_start` = 1 for exactly this cycle.
  - Load the watchdog with TIMEOUT_CYCLES - 1.
  - Go to RUN_WAIT.
- RUN_WAIT:
  - Canvas and cursor frozen; `run` ignored.
  - On `nn_done`: `result_digit` ← `nn_argmax`, `result_valid` ← 1, go to EDIT.
  - If the watchdog reaches 0 without `nn_done`: `timeout` ← 1, `result_digit` = 4'hF, go to EDIT.
  - `nn_done` in the same cycle the watchdog reaches 0: done wins.
- `nn_argmax` ≥ 10 is latched as-is, with `result_valid` = 1; the consumer treats values > 9 as reject.
- `nn_done` outside RUN_WAIT is ignored.
- Reset values:
  - State EDIT; `pixel_data` all 0.
  - `cursor_x` = `cursor_y` = CURSOR_RST.
  - `nn_start` 0, `busy` 0, `result_valid` 0, `result_digit` 4'hF, `timeout` 0.

## Timing
- All outputs are registered.
- Move or paint at cycle T is visible on the outputs at T+1.
- `run` at T:
  - T+1: `nn_start` = 1, `busy` = 1.
  - T+2: state is RUN_WAIT, `nn_start` = 0.
- `nn_done` sampled at D: `result_valid` = 1 and `busy` = 0 at D+1; a new `run` is accepted at D+1.
- Timeout: with the first RUN_WAIT cycle at W, abort is at W + TIMEOUT_CYCLES - 1; flags are visible the following cycle.
- Reset mid-run: the block returns to reset values next cycle. The network is not reset by this block and must share `resetn`.
- `pixel_data` is stable from the `run` cycle until the block leaves RUN_WAIT.

## Configuration
- `CANVAS_BRUSH3_EN` defined: paint writes the 3x3 block centred on the cursor; cells outside 0..27 are dropped with no wrap to adjacent rows.
- Undefined: paint writes only the cursor pixel.

## Structure
- Package `canvas_pkg` holds:
  - constants `CANVAS_DIM` = 28, `CANVAS_PIX` = 784, `DIGIT_INVALID` = 4'hF;
  - the state enum typedef;
  - function `pix_index(x, y)`.
- One sub-module, `canvas_brush_mask`: combinational. Maps (`cursor_x`, `cursor_y`) to a 784-bit write mask, 1 or 9 bits set according to the macro. The canvas update is `pix` ← (`pix` & ~mask) | (mask & {784{ink}}).

## Test plan
- Reset, then 14 `mv_left` pulses → `cursor_x` saturates at 0, `cursor_y` stays 13, `pixel_data` = 0.
- Cursor (5,3), `paint` with `ink` = 1 for one cycle → only bit 89 set; with the macro, bits 60–62, 88–90 and 116–118 set. At cursor (0,0) with the macro → only bits 0, 1, 28, 29 set.
- Same-cycle `mv_right` and `paint` at (5,3) → bit 89 set, `cursor_x` = 6 next cycle. Same-cycle `clear` and `paint` → canvas all 0.
- `run`, network model asserts `nn_done` 50 cycles later with `nn_argmax` = 7:
  - `nn_start` high for exactly one cycle;
  - `paint` and moves ignored while `busy`;
  - `result_valid` = 1, `result_digit` = 7 at D+1.
- TIMEOUT_CYCLES = 16, model never asserts done → `timeout` = 1, `result_digit` = F, `busy` = 0 after 16 RUN_WAIT cycles. A following `run` clears `timeout`.
- `resetn` asserted during RUN_WAIT → all outputs at reset values next cycle. Subsequent `run` works normally.
